// File: rtl/mm_pkg.sv
// mm_pkg: shared TPM command/response codes, op-state and request-FSM encodings
package mm_pkg;
    localparam logic [31:0] CC_HIERARCHY_CONTROL = 32'h0000_0121;
    localparam logic [31:0] CC_SELF_TEST         = 32'h0000_0143;
    localparam logic [31:0] CC_STARTUP           = 32'h0000_0144;
    localparam logic [31:0] CC_SHUTDOWN          = 32'h0000_0145;
    localparam logic [31:0] CC_GET_CAPABILITY    = 32'h0000_017A;
    localparam logic [31:0] CC_GET_TEST_RESULT   = 32'h0000_017C;

    localparam logic [31:0] RC_SUCCESS    = 32'h0000_0000;
    localparam logic [31:0] RC_INITIALIZE = 32'h0000_0100;
    localparam logic [31:0] RC_FAILURE    = 32'h0000_0101;
    localparam logic [31:0] RC_LOCALITY   = 32'h0000_0907;

    typedef enum logic [1:0] {
        OP_INIT        = 2'd0,
        OP_OPERATIONAL = 2'd1,
        OP_FAILURE     = 2'd2
    } op_state_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DISPATCH,
        ST_RESP
    } state_e;

    // RC_SUCCESS here means "no gating rule fired, dispatch to the engine"
    function automatic logic [31:0] check_rc(input op_state_e op, input logic [31:0] cc, input logic loc_ok);
        return !loc_ok ? RC_LOCALITY
             : (op == OP_FAILURE && cc != CC_GET_TEST_RESULT && cc != CC_GET_CAPABILITY) ? RC_FAILURE
             : (op == OP_INIT && cc != CC_STARTUP) ? RC_INITIALIZE
             : (op == OP_OPERATIONAL && cc == CC_STARTUP) ? RC_INITIALIZE
             : RC_SUCCESS;
    endfunction
endpackage

// File: rtl/mm_rr_arbiter.sv
// mm_rr_arbiter: one-hot round-robin grant, lowest index at or after the pointer wins
module mm_rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic          en_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] ptr_o
);
    logic [PW-1:0] idx;

    // Scan from the farthest offset down so the nearest requester overwrites last
    always_comb begin
        gnt_o = '0;
        ptr_o = ptr_i;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr_i) + i) % N);
            if (en_i && req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                ptr_o      = PW'((int'(idx) + 1) % N);
            end
        end
    end
endmodule

// File: rtl/mm_cmd_dispatcher.sv
// mm_cmd_dispatcher: multi-channel TPM command admission with op-state gating,
// locality filter and execution watchdog
module mm_cmd_dispatcher
    import mm_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 1024,
    parameter int CH_W    = $clog2(NUM_CH)
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic [NUM_CH-1:0]    req_valid_i,
    output logic [NUM_CH-1:0]    req_ready_o,
    input  logic [32*NUM_CH-1:0] req_cc_i,
    input  logic [3*NUM_CH-1:0]  req_loc_i,
    input  logic [4:0]           loc_allow_i,
    output logic                 exec_valid_o,
    output logic [31:0]          exec_cc_o,
    input  logic                 exec_done_i,
    input  logic [31:0]          exec_rc_i,
    output logic                 exec_abort_o,
    input  logic                 selftest_fail_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [CH_W-1:0]      resp_ch_o,
    output logic [31:0]          resp_rc_o,
    output logic [1:0]           op_state_o
);
    localparam int WD_W = $clog2(TIMEOUT);

    state_e            state_q, state_d;
    op_state_e         op_q, op_d;
    logic [NUM_CH-1:0] ready_q, ready_d;
    logic [CH_W-1:0]   ptr_q, ptr_d, ch_q, ch_d;
    logic [31:0]       cc_q, cc_d, rc_q, rc_d;
    logic [2:0]        loc_q, loc_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              abort_q, abort_d;

    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   ptr_nxt, gnt_idx;
    logic [31:0]       gnt_cc, gate_rc;
    logic [2:0]        gnt_loc;
    logic [7:0]        allow_ext;
    logic              expire;

    mm_rr_arbiter #(.N(NUM_CH), .PW(CH_W)) u_arb (
        .req_i (req_valid_i),
        .en_i  (state_q == ST_IDLE && ~|ready_q),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .ptr_o (ptr_nxt)
    );

    always_comb begin
        gnt_idx = '0;
        gnt_cc  = '0;
        gnt_loc = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt[k]) begin
                gnt_idx = CH_W'(k);
                gnt_cc  = req_cc_i[32*k +: 32];
                gnt_loc = req_loc_i[3*k +: 3];
            end
        end
    end

    // Localities 5..7 land on the zero-padded bits and are always rejected
    assign allow_ext = {3'b000, loc_allow_i};
    assign gate_rc   = check_rc(op_q, cc_q, allow_ext[loc_q]);
    assign expire    = wd_q == WD_W'(TIMEOUT - 1);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            op_q    <= OP_INIT;
            ready_q <= '0;
            ptr_q   <= '0;
            ch_q    <= '0;
            cc_q    <= '0;
            rc_q    <= '0;
            loc_q   <= '0;
            wd_q    <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ready_q <= ready_d;
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            cc_q    <= cc_d;
            rc_q    <= rc_d;
            loc_q   <= loc_d;
            wd_q    <= wd_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ready_d = '0;
        ptr_d   = ptr_q;
        ch_d    = ch_q;
        cc_d    = cc_q;
        rc_d    = rc_q;
        loc_d   = loc_q;
        wd_d    = wd_q;
        abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|ready_q) begin
                    state_d = ST_CHECK;
                end else if (|gnt) begin
                    ready_d = gnt;
                    ptr_d   = ptr_nxt;
                    ch_d    = gnt_idx;
                    cc_d    = gnt_cc;
                    loc_d   = gnt_loc;
                end
            end
            ST_CHECK: begin
                rc_d    = gate_rc;
                wd_d    = '0;
                state_d = (gate_rc == RC_SUCCESS) ? ST_DISPATCH : ST_RESP;
            end
            ST_DISPATCH: begin
                if (exec_done_i) begin
                    rc_d    = exec_rc_i;
                    state_d = ST_RESP;
                    op_d    = (exec_rc_i == RC_FAILURE) ? OP_FAILURE
                            : (exec_rc_i == RC_SUCCESS && cc_q == CC_STARTUP) ? OP_OPERATIONAL
                            : (exec_rc_i == RC_SUCCESS && cc_q == CC_SHUTDOWN) ? OP_INIT
                            : op_q;
                end else if (expire) begin
                    abort_d = 1'b1;
                    rc_d    = RC_FAILURE;
                    op_d    = OP_FAILURE;
                    state_d = ST_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_RESP: state_d = resp_ready_i ? ST_IDLE : ST_RESP;
            default: state_d = ST_IDLE;
        endcase
        if (op_q == OP_FAILURE || selftest_fail_i) op_d = OP_FAILURE;
    end

    always_comb begin
        req_ready_o  = ready_q;
        exec_valid_o = state_q == ST_DISPATCH;
        exec_cc_o    = cc_q;
        exec_abort_o = abort_q;
        resp_valid_o = state_q == ST_RESP;
        resp_ch_o    = ch_q;
        resp_rc_o    = rc_q;
        op_state_o   = op_q;
    end
endmodule
